// File: rtl/lcd_gdram_bus_rx_if.sv
// Parallel ST7920-style LCD bus (rs/rw/en/data) between a display controller and a responder.
interface lcd_gdram_bus_rx_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  modport master (output lcd_rs, output lcd_rw, output lcd_en, output lcd_data);
  modport slave  (input  lcd_rs, input  lcd_rw, input  lcd_en, input  lcd_data);
endinterface

// File: rtl/lcd_gdram_bus_rx.sv
// Responder for the ST7920-style LCD bus: decodes instructions and turns data bytes into GDRAM writes.
// Optional busy/overrun emulation is enabled by defining LCD_RX_BUSY_EN.
module lcd_gdram_bus_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUSY_CYCLES = 2500
) (
  input  logic                clk,
  input  logic                rst,
  lcd_gdram_bus_rx_if.slave   bus,
  output logic                cmd_valid,
  output logic [7:0]          cmd_byte,
  output logic                gd_we,
  output logic [9:0]          gd_addr,
  output logic [7:0]          gd_wdata,
  output logic                ext_mode,
  output logic                graphic_on,
  output logic                disp_on,
  output logic                frame_done,
  output logic                addr_err,
  output logic                busy
);

  localparam int unsigned BUS_W = 11;

  typedef enum logic {WAIT_Y, WAIT_X} phase_t;

  logic [BUS_W-1:0] sync_q [SYNC_STAGES];
  logic             en_prev_q;
  logic             en_s, rs_s, rw_s;
  logic [7:0]       data_s;
  logic             accept;
  logic             overrun;

  // en/rs/rw/data share one synchronizer chain so they stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      en_prev_q <= en_s;
    end
  end

  assign en_s   = sync_q[SYNC_STAGES-1][10];
  assign rs_s   = sync_q[SYNC_STAGES-1][9];
  assign rw_s   = sync_q[SYNC_STAGES-1][8];
  assign data_s = sync_q[SYNC_STAGES-1][7:0];
  assign accept = en_prev_q & ~en_s & ~rw_s;

`ifdef LCD_RX_BUSY_EN
  logic [15:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (accept)                busy_cnt_d = 16'(BUSY_CYCLES);
    else if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_q <= '0;
      busy       <= 1'b0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
      busy       <= (busy_cnt_d != '0);
    end
  end

  assign overrun = accept & busy;
`else
  assign busy    = 1'b0;
  assign overrun = 1'b0;
`endif

  phase_t     phase_q, phase_d;
  logic [4:0] y_q, y_d;
  logic [3:0] x_q, x_d;
  logic       bs_q, bs_d;
  logic       av_q, av_d;
  logic       cmd_valid_d, gd_we_d, ext_d, gr_d, disp_d, fd_d, err_d;
  logic [7:0] cmd_byte_d, gd_wdata_d;
  logic [9:0] gd_addr_d;

  // Instruction decode, GDRAM address sequencer and data write path
  always_comb begin
    phase_d     = phase_q;
    y_d         = y_q;
    x_d         = x_q;
    bs_d        = bs_q;
    av_d        = av_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte;
    gd_we_d     = 1'b0;
    gd_addr_d   = gd_addr;
    gd_wdata_d  = gd_wdata;
    ext_d       = ext_mode;
    gr_d        = graphic_on;
    disp_d      = disp_on;
    fd_d        = 1'b0;
    err_d       = addr_err | overrun;

    if (accept) begin
      if (!rs_s) begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = data_s;
        if (!(ext_mode && data_s[7]) && phase_q == WAIT_X) phase_d = WAIT_Y;

        if (data_s[7:5] == 3'b001) begin
          ext_d = data_s[2];
          if (data_s[2]) gr_d = data_s[1];
        end else if (!ext_mode) begin
          if (data_s[7:3] == 5'b0_0001) begin
            disp_d = data_s[2];
          end else if (data_s == 8'h01) begin
            y_d  = '0;
            x_d  = '0;
            bs_d = 1'b0;
            av_d = 1'b0;
          end
        end else if (data_s[7]) begin
          if (phase_q == WAIT_Y) begin
            y_d     = data_s[4:0];
            phase_d = WAIT_X;
            if (data_s[6:5] != 2'b00) err_d = 1'b1;
          end else begin
            x_d     = data_s[3:0];
            bs_d    = 1'b0;
            av_d    = 1'b1;
            phase_d = WAIT_Y;
            if (data_s[6:4] != 3'b000) err_d = 1'b1;
          end
        end
      end else if (!av_q || !ext_mode || phase_q == WAIT_X) begin
        err_d = 1'b1;
      end else begin
        gd_we_d    = 1'b1;
        gd_addr_d  = {y_q, x_q, bs_q};
        gd_wdata_d = data_s;
        fd_d       = ({y_q, x_q, bs_q} == 10'h3FF);
        bs_d       = ~bs_q;
        // X wraps within the row; Y is left alone like the real controller
        if (bs_q) x_d = x_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q    <= WAIT_Y;
      y_q        <= '0;
      x_q        <= '0;
      bs_q       <= 1'b0;
      av_q       <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      gd_we      <= 1'b0;
      gd_addr    <= '0;
      gd_wdata   <= '0;
      ext_mode   <= 1'b0;
      graphic_on <= 1'b0;
      disp_on    <= 1'b0;
      frame_done <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      y_q        <= y_d;
      x_q        <= x_d;
      bs_q       <= bs_d;
      av_q       <= av_d;
      cmd_valid  <= cmd_valid_d;
      cmd_byte   <= cmd_byte_d;
      gd_we      <= gd_we_d;
      gd_addr    <= gd_addr_d;
      gd_wdata   <= gd_wdata_d;
      ext_mode   <= ext_d;
      graphic_on <= gr_d;
      disp_on    <= disp_d;
      frame_done <= fd_d;
      addr_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_lcd_gdram_bus_rx.sv
// Scoreboard bench for lcd_gdram_bus_rx: stimulus queues expected strobes, a monitor pops and compares.
module tb_lcd_gdram_bus_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, gd_we, ext_mode, graphic_on, disp_on, frame_done, addr_err, busy;
  logic [7:0] cmd_byte, gd_wdata;
  logic [9:0] gd_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  cmd_exp_q [$];
  logic [18:0] gd_exp_q  [$];   // {frame_done, addr, data}

  lcd_gdram_bus_rx_if bus ();

  lcd_gdram_bus_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cmd_valid  (cmd_valid),
    .cmd_byte   (cmd_byte),
    .gd_we      (gd_we),
    .gd_addr    (gd_addr),
    .gd_wdata   (gd_wdata),
    .ext_mode   (ext_mode),
    .graphic_on (graphic_on),
    .disp_on    (disp_on),
    .frame_done (frame_done),
    .addr_err   (addr_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of its expectation queue
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cmd_valid) begin
        if (cmd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got %h expected none (t=%0t)", cmd_byte, $time);
        end else begin
          chk("cmd_byte", 32'(cmd_byte), 32'(cmd_exp_q.pop_front()));
        end
      end
      if (gd_we) begin
        if (gd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_gd_we: got addr %h data %h expected none (t=%0t)", gd_addr, gd_wdata, $time);
        end else begin
          chk("gd_write", 32'({frame_done, gd_addr, gd_wdata}), 32'(gd_exp_q.pop_front()));
        end
      end else if (frame_done) begin
        checks++; errors++;
        $display("FAIL frame_done_alone: got 1 expected 0 (t=%0t)", $time);
      end
    end
  end

  task automatic wait_not_busy();
`ifdef LCD_RX_BUSY_EN
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
`endif
  endtask

  task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d, input bit no_wait = 1'b0);
    if (!no_wait) wait_not_busy();
    if (!rs && !rw) cmd_exp_q.push_back(d);
    @(posedge clk); #2;
    bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_data = d;
    bus.lcd_en = 1'b1;
    repeat (4) @(posedge clk);
    #2 bus.lcd_en = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic gd_write(input logic [7:0] d, input logic [9:0] addr, input logic fd);
    gd_exp_q.push_back({fd, addr, d});
    bus_write(1'b1, 1'b0, d);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 32'({cmd_valid, cmd_byte, gd_we, gd_addr, gd_wdata, ext_mode,
                   graphic_on, disp_on, frame_done, addr_err, busy}), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_en = 1'b0; bus.lcd_data = '0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_outputs");

    // Init sequence: basic function set, entry mode, display on, extended+graphic
    bus_write(1'b0, 1'b0, 8'h30);
    bus_write(1'b0, 1'b0, 8'h06);
    bus_write(1'b0, 1'b0, 8'h0C);
    bus_write(1'b0, 1'b0, 8'h36);
    @(negedge clk);
    chk("init_disp_on",    32'(disp_on),    32'd1);
    chk("init_ext_mode",   32'(ext_mode),   32'd1);
    chk("init_graphic_on", 32'(graphic_on), 32'd1);
    chk("init_addr_err",   32'(addr_err),   32'd0);
    chk("init_busy",       32'(busy),       32'(0));

    // Y=5, X=3 -> {00101,0011,bs}
    bus_write(1'b0, 1'b0, 8'h36);
    bus_write(1'b0, 1'b0, 8'h85);
    bus_write(1'b0, 1'b0, 8'h83);
    gd_write(8'hAA, 10'h0A6, 1'b0);
    gd_write(8'h55, 10'h0A7, 1'b0);
    gd_write(8'h77, 10'h0A8, 1'b0);

    // Last word of the frame, then X wraps within row 31
    bus_write(1'b0, 1'b0, 8'h9F);
    bus_write(1'b0, 1'b0, 8'h8F);
    gd_write(8'h11, 10'h3FE, 1'b0);
    gd_write(8'h22, 10'h3FF, 1'b1);
    gd_write(8'h33, 10'h3E0, 1'b0);
    @(negedge clk);
    chk("hold_gd_addr",  32'(gd_addr),  32'h3E0);
    chk("hold_gd_wdata", 32'(gd_wdata), 32'h33);
    chk("seq_addr_err",  32'(addr_err), 32'd0);

    // Reset while en is high; en drops during reset so no fall must follow
    @(posedge clk); #2;
    bus.lcd_rs = 1'b0; bus.lcd_data = 8'h0C; bus.lcd_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #3;
    check_all_zero("midreset_outputs");
    bus.lcd_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check_all_zero("post_reset_outputs");

    // Basic mode: 0x85 is a DDRAM address, data without GDRAM setup is an error
    bus_write(1'b0, 1'b0, 8'h85);
    bus_write(1'b0, 1'b0, 8'h0C);
    bus_write(1'b1, 1'b0, 8'h5A);
    @(negedge clk);
    chk("nosetup_addr_err", 32'(addr_err), 32'd1);
    chk("nosetup_disp_on",  32'(disp_on),  32'd1);

    // Read cycles are ignored entirely
    bus_write(1'b0, 1'b1, 8'h36);
    bus_write(1'b1, 1'b1, 8'h99);
    @(negedge clk);
    chk("read_ext_mode", 32'(ext_mode), 32'd0);
    chk("read_graphic",  32'(graphic_on), 32'd0);

`ifdef LCD_RX_BUSY_EN
    // Overrun: second byte well inside the busy window
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    bus_write(1'b0, 1'b0, 8'h30);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("busy_high",       32'(busy),     32'd1);
    chk("busy_no_err_yet", 32'(addr_err), 32'd0);
    bus_write(1'b0, 1'b0, 8'h30, 1'b1);
    @(negedge clk);
    chk("overrun_addr_err", 32'(addr_err), 32'd1);
`endif

    repeat (5) @(posedge clk);
    chk("cmd_queue_drained", 32'(cmd_exp_q.size()), 32'd0);
    chk("gd_queue_drained",  32'(gd_exp_q.size()),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
